// File: rtl/image_store_encode.sv
// Avalon-ST video packetiser: wraps each raw sop..eop pixel frame in an optional
// control packet (type 0xF, nibble-packed width/height/interlace) and a type-0 video packet.
module image_store_encode #(
   parameter int DATA_WIDTH   = 24,
   parameter int COLOR_BITS   = 8,
   parameter int COLOR_PLANES = 3,
   parameter int SEND_CTRL    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           im_width,
   input  logic [15:0]           im_height,
   input  logic [3:0]            im_interlaced,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic                  din_valid,
   input  logic                  din_startofpacket,
   input  logic                  din_endofpacket,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_valid,
   output logic                  dout_startofpacket,
   output logic                  dout_endofpacket,
   input  logic                  dout_ready
);

   localparam int NIBS  = 9;
   localparam int BEATS = (NIBS + COLOR_PLANES - 1) / COLOR_PLANES;
   localparam int CW    = $clog2(BEATS + 1);

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      CTRL_HDR  = 5'b00010,
      CTRL_DATA = 5'b00100,
      VID_HDR   = 5'b01000,
      VID_DATA  = 5'b10000
   } state_t;

   state_t          state, nxt_state;
   logic [15:0]     wid_q, hgt_q;
   logic [3:0]      intl_q;
   logic [CW-1:0]   cnt;
   logic            latch, cnt_inc;
   logic            last_beat;
   logic [DATA_WIDTH-1:0] payload;

   logic                  rdy_c, vld_c, sop_c, eop_c;
   logic [DATA_WIDTH-1:0] data_c;

   // Nibble n of the header, n=0 being W[15:12]; anything past the interlace nibble is 0.
   function automatic logic [3:0] nib_at(input logic [35:0] f, input int n);
      logic [35:0] sh;
      sh = f << (4 * n);
      return (n < NIBS) ? sh[35:32] : 4'h0;
   endfunction

   assign last_beat = (cnt == CW'(BEATS - 1));

   always_comb begin
      payload = '0;
      for (int s = 0; s < COLOR_PLANES; s++)
         payload[s*COLOR_BITS +: 4] = nib_at({wid_q, hgt_q, intl_q},
                                             int'(cnt) * COLOR_PLANES + s);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      rdy_c     = 1'b0;
      vld_c     = 1'b0;
      sop_c     = 1'b0;
      eop_c     = 1'b0;
      data_c    = '0;
      latch     = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            rdy_c = 1'b1;
            // Hold the sop pixel back; it is forwarded once the headers are out.
            if (din_valid && din_startofpacket) begin
               rdy_c     = 1'b0;
               latch     = 1'b1;
               nxt_state = (SEND_CTRL != 0) ? CTRL_HDR : VID_HDR;
            end
         end
         CTRL_HDR: begin
            vld_c      = 1'b1;
            sop_c      = 1'b1;
            data_c[3:0] = 4'hF;
            if (dout_ready) nxt_state = CTRL_DATA;
         end
         CTRL_DATA: begin
            vld_c  = 1'b1;
            eop_c  = last_beat;
            data_c = payload;
            if (dout_ready) begin
               if (last_beat) nxt_state = VID_HDR;
               else           cnt_inc   = 1'b1;
            end
         end
         VID_HDR: begin
            vld_c = 1'b1;
            sop_c = 1'b1;
            if (dout_ready) nxt_state = VID_DATA;
         end
         VID_DATA: begin
            data_c = din_data;
            vld_c  = din_valid;
            rdy_c  = dout_ready;
            eop_c  = din_endofpacket;
            if (din_valid && dout_ready && din_endofpacket) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wid_q  <= '0;
         hgt_q  <= '0;
         intl_q <= '0;
         cnt    <= '0;
      end else begin
         if (latch) begin
            wid_q  <= im_width;
            hgt_q  <= im_height;
            intl_q <= im_interlaced;
         end
         if (state != CTRL_DATA) cnt <= '0;
         else if (cnt_inc)       cnt <= cnt + 1'b1;
      end
   end

   // Outputs collapse to 0 while reset is held, even mid-cycle.
   assign din_ready          = rst ? 1'b0 : rdy_c;
   assign dout_valid         = rst ? 1'b0 : vld_c;
   assign dout_startofpacket = rst ? 1'b0 : sop_c;
   assign dout_endofpacket   = rst ? 1'b0 : eop_c;
   assign dout_data          = rst ? '0   : data_c;

endmodule
